// File: rtl/rc_responder.sv
// rc_responder
//   RC-side endpoint for the gateway's RC transfer interface. Each one-cycle
//   write/read transfer pulse is serviced against an internal register file
//   of DEPTH 32-bit words. A response pulse follows RESP_LAT cycles after the
//   request is accepted. Requests that arrive while a transfer is in flight,
//   or a read that collides with a write, are dropped and counted.
//
// Ports:
//   clk                  clock
//   rstn                 asynchronous active-low reset
//   address              byte address, sampled with a transfer pulse
//   data_in              write data, sampled with write_transfer_valid
//   write_transfer_valid one-cycle write request
//   read_transfer_valid  one-cycle read request
//   data_out             read data; held until the next read response
//   write_resp_valid     one-cycle write-complete pulse
//   read_resp_valid      one-cycle read-data-valid pulse
//   busy                 request in flight
//   err_cnt              saturating count of out-of-range/misaligned accesses
//   drop_cnt             saturating count of dropped requests

module rc_responder #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned RESP_LAT = 2,
    parameter logic [31:0] OOR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        write_transfer_valid,
    input  logic        read_transfer_valid,
    output logic [31:0] data_out,
    output logic        write_resp_valid,
    output logic        read_resp_valid,
    output logic        busy,
    output logic [7:0]  err_cnt,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned IW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_LOAD = 4'(RESP_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          is_wr_q, is_wr_d;
    logic [31:0]   dout_hold_q, dout_hold_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    drop_q, drop_d;
    logic [31:0]   mem_q [DEPTH];

    logic          addr_ok;
    logic [IW-1:0] idx;
    logic [31:0]   rd_val;
    logic          mem_we;
    logic          drop_evt;

    // Word aligned and inside the register file (DEPTH is a power of two,
    // so "word index < DEPTH" is "all bits above the index are zero").
    assign addr_ok = (addr_q[1:0] == 2'b00) && (addr_q[31:IW+2] == '0);
    assign idx     = addr_q[IW+1:2];
    assign rd_val  = addr_ok ? mem_q[idx] : OOR_DATA;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        dout_hold_d = dout_hold_q;
        err_d       = err_q;
        drop_d      = drop_q;
        mem_we      = 1'b0;
        drop_evt    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (write_transfer_valid || read_transfer_valid) begin
                    addr_d   = address;
                    wdata_d  = data_in;
                    is_wr_d  = write_transfer_valid;   // write wins a collision
                    cnt_d    = CNT_LOAD;
                    drop_evt = write_transfer_valid && read_transfer_valid;
                    state_d  = (RESP_LAT == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                drop_evt = write_transfer_valid || read_transfer_valid;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                drop_evt = write_transfer_valid || read_transfer_valid;
                state_d  = ST_IDLE;
                if (is_wr_q) begin
                    mem_we = addr_ok;
                end else begin
                    dout_hold_d = rd_val;
                end
                if (!addr_ok && (err_q != 8'hFF)) begin
                    err_d = err_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (drop_evt && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            dout_hold_q <= '0;
            err_q       <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            dout_hold_q <= dout_hold_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
        end
    end

    // NOTE: the register file must read as zero after reset, so it is built
    // from resettable flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    // Responses are decoded from registered state, so reset clears them at once.
    assign busy             = (state_q != ST_IDLE);
    assign write_resp_valid = (state_q == ST_RESP) && is_wr_q;
    assign read_resp_valid  = (state_q == ST_RESP) && !is_wr_q;
    assign data_out         = read_resp_valid ? rd_val : dout_hold_q;
    assign err_cnt          = err_q;
    assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_rc_responder.sv
// Testbench for rc_responder (DEPTH=16, RESP_LAT=2).
// A transaction-level model tracks when each accepted request responds
// (acceptance cycle + RESP_LAT), a word array for the register file and
// plain integer counters; every cycle the DUT outputs are compared with it.

module tb_rc_responder;

    localparam int          DEPTH = 16;
    localparam int          LAT   = 2;
    localparam logic [31:0] OOR   = 32'hDEAD_BEEF;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        write_transfer_valid;
    logic        read_transfer_valid;
    logic [31:0] data_out;
    logic        write_resp_valid;
    logic        read_resp_valid;
    logic        busy;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;

    rc_responder #(
        .DEPTH   (DEPTH),
        .RESP_LAT(LAT),
        .OOR_DATA(OOR)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .address             (address),
        .data_in             (data_in),
        .write_transfer_valid(write_transfer_valid),
        .read_transfer_valid (read_transfer_valid),
        .data_out            (data_out),
        .write_resp_valid    (write_resp_valid),
        .read_resp_valid     (read_resp_valid),
        .busy                (busy),
        .err_cnt             (err_cnt),
        .drop_cnt            (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_dout;
    int          m_err;
    int          m_drop;
    int          cyc;
    int          acc_cyc;
    int          resp_cyc;
    bit          p_wr;
    logic [31:0] p_addr;
    logic [31:0] p_data;

    function automatic bit m_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:2] < 30'(DEPTH));
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'(a[31:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_dout   = '0;
        m_err    = 0;
        m_drop   = 0;
        acc_cyc  = -100;
        resp_cyc = -100;
        p_wr     = 1'b0;
        p_addr   = '0;
        p_data   = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     32'(busy),             32'd0);
        check({tag, "_wresp"},    32'(write_resp_valid), 32'd0);
        check({tag, "_rresp"},    32'(read_resp_valid),  32'd0);
        check({tag, "_data_out"}, data_out,              32'd0);
        check({tag, "_err_cnt"},  32'(err_cnt),          32'd0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt),         32'd0);
    endtask

    // One clock cycle: entered at a negedge. Check this cycle's outputs,
    // drive this cycle's inputs, advance the model over the closing edge.
    task automatic step(input bit wv, input bit rv, input logic [31:0] a, input logic [31:0] d);
        bit in_resp;
        in_resp = (cyc == resp_cyc);
        if (in_resp && !p_wr) m_dout = m_ok(p_addr) ? m_mem[m_idx(p_addr)] : OOR;

        check("busy",             32'(busy),             32'(cyc > acc_cyc && cyc <= resp_cyc));
        check("write_resp_valid", 32'(write_resp_valid), 32'(in_resp && p_wr));
        check("read_resp_valid",  32'(read_resp_valid),  32'(in_resp && !p_wr));
        check("data_out",         data_out,              m_dout);
        check("err_cnt",          32'(err_cnt),          32'(m_err));
        check("drop_cnt",         32'(drop_cnt),         32'(m_drop));

        write_transfer_valid = wv;
        read_transfer_valid  = rv;
        address              = a;
        data_in              = d;

        if (in_resp) begin
            if (p_wr && m_ok(p_addr)) m_mem[m_idx(p_addr)] = p_data;
            if (!m_ok(p_addr) && m_err < 255) m_err++;
        end
        if (cyc > resp_cyc) begin
            if (wv || rv) begin
                acc_cyc  = cyc;
                resp_cyc = cyc + LAT;
                p_wr     = wv;
                p_addr   = a;
                p_data   = d;
                if (wv && rv && m_drop < 255) m_drop++;
            end
        end else if ((wv || rv) && m_drop < 255) begin
            m_drop++;
        end

        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
        idle(LAT);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b0, 1'b1, a, '0);
        idle(LAT);
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        int          k;
        bit          wv;
        bit          rv;

        write_transfer_valid = 1'b0;
        read_transfer_valid  = 1'b0;
        address              = '0;
        data_in              = '0;
        model_reset();
        cyc  = 0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;

        // Basic write then read, same address.
        wr(32'h8, 32'h1234_5678);
        rd(32'h8);
        check("basic_rd_data", data_out, 32'h1234_5678);

        // Out-of-range read, misaligned write.
        rd(32'h40);
        check("oor_rd_data", data_out, 32'hDEAD_BEEF);
        check("oor_err_cnt", 32'(err_cnt), 32'd1);
        wr(32'h6, 32'hFFFF_FFFF);
        check("misal_err_cnt", 32'(err_cnt), 32'd2);
        rd(32'h4);
        check("misal_no_corrupt", data_out, 32'h0);
        rd(32'h8);

        // Collision: write accepted, read dropped, data_out untouched.
        step(1'b1, 1'b1, 32'hC, 32'hAAAA_5555);
        idle(LAT);
        check("collide_drop_cnt", 32'(drop_cnt), 32'd1);
        check("collide_data_out", data_out, 32'h1234_5678);

        // Read issued in the WAIT cycle of a write is dropped.
        step(1'b1, 1'b0, 32'h10, 32'h0BAD_CAFE);
        step(1'b0, 1'b1, 32'h10, '0);
        idle(LAT - 1);
        check("busy_drop_cnt", 32'(drop_cnt), 32'd2);
        rd(32'h10);
        check("busy_wr_data", data_out, 32'h0BAD_CAFE);
        rd(32'hC);
        check("collide_wr_data", data_out, 32'hAAAA_5555);

        // Drop counter saturation.
        repeat (300) step(1'b1, 1'b1, 32'h14, $urandom);
        idle(LAT + 1);
        check("drop_saturate", 32'(drop_cnt), 32'd255);

        // Reset in the middle of a write.
        step(1'b1, 1'b0, 32'h0, 32'hCAFE_F00D);
        check("rst_mid_busy", 32'(busy), 32'd1);
        write_transfer_valid = 1'b0;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all_zero("rst_mid");
        @(negedge clk);
        cyc++;
        check_all_zero("rst_hold");
        rstn = 1'b1;
        idle(LAT + 1);
        rd(32'h0);
        check("rst_no_commit", data_out, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            r  = $urandom_range(0, 9);
            wv = (r < 3) || (r == 9);
            rv = (r >= 3 && r < 6) || (r == 9);
            k  = $urandom_range(0, 7);
            if (k < 5)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (k == 5) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (k == 6) a = 32'($urandom_range(DEPTH, 4096)) << 2;
            else             a = $urandom;
            step(wv, rv, a, $urandom);
        end
        idle(LAT + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
